multicycle_control: RTL

Sequencing controller for the multi-cycle build of the MIPS datapath. It replaces the single-cycle combinational decoder with a Moore-style FSM that steps each instruction through fetch, decode, execute, memory and write-back cycles. It drives every datapath select and write-enable, and stalls on a single shared instruction/data memory through a ready handshake. It also keeps a retired-instruction counter for bench and debug use.

---
 rtl/multicycle_control.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS sequencing FSM with retired-instruction counter
module multicycle_control (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  opcode,
   input  logic        mem_ready,
   output logic        PCWrite,
   output logic        PCWriteCond,
   output logic        IorD,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        IRWrite,
   output logic        MemToReg,
   output logic        RegWrite,
   output logic        RegDst,
   output logic        ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  PCSrc,
   output logic [2:0]  ALUOp,
   output logic [3:0]  state,
   output logic        illegal,
   output logic [31:0] instr_count
);

   localparam logic [3:0] S_IDLE    = 4'd0;
   localparam logic [3:0] S_FETCH   = 4'd1;
   localparam logic [3:0] S_DECODE  = 4'd2;
   localparam logic [3:0] S_MEMADR  = 4'd3;
   localparam logic [3:0] S_MEMRD   = 4'd4;
   localparam logic [3:0] S_MEMWB   = 4'd5;
   localparam logic [3:0] S_MEMWR   = 4'd6;
   localparam logic [3:0] S_EXEC    = 4'd7;
   localparam logic [3:0] S_RWB     = 4'd8;
   localparam logic [3:0] S_BRANCH  = 4'd9;
   localparam logic [3:0] S_ADDIEX  = 4'd10;
   localparam logic [3:0] S_ADDIWB  = 4'd11;
   localparam logic [3:0] S_JUMP    = 4'd12;
   localparam logic [3:0] S_ILLEGAL = 4'd15;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] SRCB_B    = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_IMM4 = 2'b11;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_FUNCT = 3'b010;

   logic [3:0]  state_q, state_d;
   logic [31:0] instr_count_q, instr_count_d;
   logic        retire;

   // Next-state selection; opcode only matters in DECODE and MEMADR
   always_comb begin
      state_d = state_q;
      retire  = 1'b0;
      case (state_q)
         S_IDLE:   state_d = S_FETCH;
         S_FETCH:  if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_RTYPE:     state_d = S_EXEC;
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
               default:      state_d = S_ILLEGAL;
            endcase
         end
         S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
         S_MEMWB: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         S_MEMWR: begin
            if (mem_ready) begin
               state_d = S_FETCH;
               retire  = 1'b1;
            end
         end
         S_EXEC:   state_d = S_RWB;
         S_RWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         S_ADDIEX:  state_d = S_ADDIWB;
         S_ILLEGAL: state_d = S_ILLEGAL;
         // Unused codes 13/14 are treated as a corrupted sequencer
         default:   state_d = S_ILLEGAL;
      endcase
   end

   // Retired-instruction counter wraps naturally at 32 bits
   always_comb begin
      instr_count_d = instr_count_q;
      if (retire) instr_count_d = instr_count_q + 32'd1;
   end

   // State and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         instr_count_q <= 32'd0;
      end else begin
         state_q       <= state_d;
         instr_count_q <= instr_count_d;
      end
   end

   // Datapath controls from state alone, except the FETCH ready-gated writes
   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemToReg    = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = SRCB_B;
      PCSrc       = PC_ALU;
      ALUOp       = ALU_ADD;
      illegal     = 1'b0;
      case (state_q)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = SRCB_FOUR;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
         end
         S_DECODE: ALUSrcB = SRCB_IMM4;
         S_MEMADR, S_ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         S_MEMWB: begin
            MemToReg = 1'b1;
            RegWrite = 1'b1;
         end
         S_MEMWR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
         end
         S_EXEC: begin
            ALUSrcA = 1'b1;
            ALUOp   = ALU_FUNCT;
         end
         S_RWB: begin
            RegDst   = 1'b1;
            RegWrite = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUOp       = ALU_SUB;
            PCSrc       = PC_ALUOUT;
            PCWriteCond = 1'b1;
         end
         S_ADDIWB: RegWrite = 1'b1;
         S_JUMP: begin
            PCSrc   = PC_JUMP;
            PCWrite = 1'b1;
         end
         S_ILLEGAL: illegal = 1'b1;
         default: ;
      endcase
   end

   assign state       = state_q;
   assign instr_count = instr_count_q;

endmodule
